// File: rtl/uart_tx_if.sv
// Parallel-side bundle for the UART transmitter: byte request, frame options, line and busy.
// master drives the request, slave is the transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      data_valid;
    logic                      par_en;
    logic                      par_type;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      tx_out;
    logic                      busy;

    modport master (
        output p_data, data_valid, par_en, par_type, prescale,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_type, prescale,
        output tx_out, busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s), prescale cycles per bit.
// Build option UART_TX_TWO_STOP_EN: when defined the frame ends with two stop bits instead of one.
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(1);
`else
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(0);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the data; odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                    state_r, state_nxt_s;
    logic [PRESCALE_WIDTH-1:0] cyc_cnt_r, cyc_nxt_s;
    logic [BIT_W-1:0]          bit_cnt_r, bit_nxt_s;
    logic [DATA_WIDTH-1:0]     data_r;
    logic                      par_en_r;
    logic                      par_type_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic                      tx_r, tx_nxt_s;
    logic                      busy_r, busy_nxt_s;
    logic                      load_s;
    logic                      last_cyc_s;

    // prescale 0 makes P-1 wrap to all ones, i.e. a full 2**PRESCALE_WIDTH cycle bit.
    assign last_cyc_s = (cyc_cnt_r == (prescale_r - PRESCALE_WIDTH'(1)));

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_nxt_s = state_r;
        cyc_nxt_s   = cyc_cnt_r + PRESCALE_WIDTH'(1);
        bit_nxt_s   = bit_cnt_r;
        load_s      = 1'b0;
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b1;

        case (state_r)
            IDLE: begin
                cyc_nxt_s = {PRESCALE_WIDTH{1'b0}};
                bit_nxt_s = {BIT_W{1'b0}};
                if (bus.data_valid) begin
                    state_nxt_s = START;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (last_cyc_s) begin
                    cyc_nxt_s   = {PRESCALE_WIDTH{1'b0}};
                    bit_nxt_s   = {BIT_W{1'b0}};
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (last_cyc_s) begin
                    cyc_nxt_s = {PRESCALE_WIDTH{1'b0}};
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_nxt_s   = {BIT_W{1'b0}};
                        state_nxt_s = par_en_r ? PARITY : STOP;
                    end else begin
                        bit_nxt_s   = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (last_cyc_s) begin
                    cyc_nxt_s   = {PRESCALE_WIDTH{1'b0}};
                    bit_nxt_s   = {BIT_W{1'b0}};
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                // bit_cnt counts stop bits here so the two-stop build reuses the same counter.
                if (last_cyc_s) begin
                    cyc_nxt_s = {PRESCALE_WIDTH{1'b0}};
                    if (bit_cnt_r == STOP_LAST) begin
                        bit_nxt_s   = {BIT_W{1'b0}};
                        state_nxt_s = IDLE;
                    end else begin
                        bit_nxt_s   = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                cyc_nxt_s   = {PRESCALE_WIDTH{1'b0}};
                bit_nxt_s   = {BIT_W{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase

        case (state_nxt_s)
            IDLE:    busy_nxt_s = 1'b0;
            START:   tx_nxt_s   = 1'b0;
            DATA:    tx_nxt_s   = data_r[bit_nxt_s];
            PARITY:  tx_nxt_s   = parity_bit(data_r, par_type_r);
            STOP:    tx_nxt_s   = 1'b1;
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // State, counters, latched frame options and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cyc_cnt_r  <= {PRESCALE_WIDTH{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            data_r     <= {DATA_WIDTH{1'b0}};
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
            prescale_r <= {PRESCALE_WIDTH{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cyc_cnt_r <= cyc_nxt_s;
            bit_cnt_r <= bit_nxt_s;
            tx_r      <= tx_nxt_s;
            busy_r    <= busy_nxt_s;
            if (load_s) begin
                data_r     <= bus.p_data;
                par_en_r   <= bus.par_en;
                par_type_r <= bus.par_type;
                prescale_r <= bus.prescale;
            end
        end
    end

    assign bus.tx_out = tx_r;
    assign bus.busy   = busy_r;
endmodule

// File: tb/tb_uart_tx.sv
// Directed + randomized bench for uart_tx; expected line waveform is built as a per-frame bit list.
module tb_uart_tx;
    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

    uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_p(input logic [PW-1:0] ps);
        return (ps == '0) ? (1 << PW) : int'(ps);
    endfunction

    task automatic scramble();
        bus.p_data   = DW'($urandom);
        bus.par_en   = 1'($urandom);
        bus.par_type = 1'($urandom);
        bus.prescale = PW'($urandom);
    endtask

    // Present a request at a negedge; it is accepted on the following posedge.
    task automatic start_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                               input logic [PW-1:0] ps, input bit hold);
        @(negedge clk);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_type   = pt;
        bus.prescale   = ps;
        bus.data_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.data_valid = 1'b0;
            scramble();
        end
    endtask

    // Checks every cycle of one frame starting at the cycle after acceptance, then one idle cycle.
    task automatic check_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                               input int p, input int inject_at, input bit drop_first,
                               input string tag);
        logic q[$];
        int   cyc;
        cyc = 0;
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) q.push_back(d[i]);
        if (pe) q.push_back(logic'(($countones(d) % 2) == 1) ^ pt);
        for (int s = 0; s < STOP_BITS; s++) q.push_back(1'b1);
        foreach (q[k]) begin
            for (int j = 0; j < p; j++) begin
                @(negedge clk);
                chk({tag, "_tx"}, 32'(bus.tx_out), 32'(q[k]));
                chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
                if (drop_first && cyc == 0) begin
                    bus.data_valid = 1'b0;
                    scramble();
                end
                if (inject_at >= 0 && cyc == inject_at) begin
                    bus.data_valid = 1'b1;
                    bus.p_data     = 8'hFF;
                end else if (inject_at >= 0 && cyc == inject_at + 1) begin
                    bus.data_valid = 1'b0;
                end
                cyc++;
            end
        end
        @(negedge clk);
        chk({tag, "_gap_tx"}, 32'(bus.tx_out), 32'd1);
        chk({tag, "_gap_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          pe, pt;
        logic [PW-1:0] ps;

        bus.data_valid = 1'b0;
        bus.p_data     = '0;
        bus.par_en     = 1'b0;
        bus.par_type   = 1'b0;
        bus.prescale   = PW'(8);

        // Reset and idle line
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(bus.tx_out), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_tx", 32'(bus.tx_out), 32'd1);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Basic frame and parity variants
        start_frame(8'hA5, 1'b0, 1'b0, PW'(8), 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, 8, -1, 1'b0, "basic_a5");
        start_frame(8'hA5, 1'b1, 1'b0, PW'(8), 1'b0);
        check_frame(8'hA5, 1'b1, 1'b0, 8, -1, 1'b0, "even_a5");
        start_frame(8'h07, 1'b1, 1'b1, PW'(8), 1'b0);
        check_frame(8'h07, 1'b1, 1'b1, 8, -1, 1'b0, "odd_07");
        start_frame(8'h07, 1'b1, 1'b0, PW'(8), 1'b0);
        check_frame(8'h07, 1'b1, 1'b0, 8, -1, 1'b0, "even_07");

        // Request during busy is dropped, then nothing follows the frame
        start_frame(8'h3C, 1'b0, 1'b0, PW'(8), 1'b0);
        check_frame(8'h3C, 1'b0, 1'b0, 8, 30, 1'b0, "blocked_3c");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_ff_tx", 32'(bus.tx_out), 32'd1);
            chk("no_ff_busy", 32'(bus.busy), 32'd0);
        end

        // Back-to-back with data_valid held high
        start_frame(8'h96, 1'b1, 1'b1, PW'(4), 1'b1);
        bus.p_data = 8'h5A;
        check_frame(8'h96, 1'b1, 1'b1, 4, -1, 1'b0, "b2b_first");
        check_frame(8'h5A, 1'b1, 1'b1, 4, -1, 1'b1, "b2b_second");

        // Asynchronous reset in data bit 3
        d = DW'($urandom);
        start_frame(d, 1'b0, 1'b0, PW'(8), 1'b0);
        repeat (8 + 3 * 8 + 4) @(negedge clk);
        chk("pre_rst_bit3", 32'(bus.tx_out), 32'(d[3]));
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tx", 32'(bus.tx_out), 32'd1);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_tx", 32'(bus.tx_out), 32'd1);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
        end
        start_frame(8'h55, 1'b0, 1'b0, PW'(8), 1'b0);
        check_frame(8'h55, 1'b0, 1'b0, 8, -1, 1'b0, "after_rst_55");

        // Prescale extremes
        start_frame(8'h81, 1'b0, 1'b0, PW'(1), 1'b0);
        check_frame(8'h81, 1'b0, 1'b0, 1, -1, 1'b0, "ps1_81");
        d = DW'($urandom);
        start_frame(d, 1'b1, 1'b0, PW'(0), 1'b0);
        check_frame(d, 1'b1, 1'b0, 64, -1, 1'b0, "ps0");

        // Randomized frames against the bit-list model
        for (int n = 0; n < 10; n++) begin
            d  = DW'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            ps = PW'($urandom_range(1, 9));
            start_frame(d, pe, pt, ps, 1'b0);
            check_frame(d, pe, pt, eff_p(ps), -1, 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART block; the counterpart of the existing UART receive path.
- Accepts one parallel byte with a valid strobe and emits a frame on tx_out: start bit, 8 data bits LSB first, an optional parity bit, then the stop bit.
- Each bit lasts exactly prescale clock cycles, so the same prescale value gives a line rate the receiver samples correctly.
- busy lets the upstream source hold the next byte until the current frame finishes.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 6, width of the prescale input and of the internal cycle counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- p_data  input  DATA_WIDTH  byte to transmit.
- data_valid  input  1  request strobe; accepted only while busy=0.
- par_en  input  1  1 = insert parity bit.
- par_type  input  1  0 = even parity, 1 = odd parity.
- prescale  input  PRESCALE_WIDTH  clock cycles per bit.
- tx_out  output  1  serial line, idles high.
- busy  output  1  frame in progress.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst=0, asynchronous, any state, including mid-frame):
  - state=IDLE, tx_out=1, busy=0, all counters 0.
  - The frame in progress is abandoned, not completed.
- Registered outputs: tx_out and busy both come from flops; no combinational path from any input.
- Acceptance:
  - In IDLE with data_valid=1 at edge N, the block latches p_data, par_en, par_type and prescale.
  - At N+1: state=START, tx_out=0, busy=1.
  - data_valid while busy=1 is ignored, and nothing is queued.
  - Changes on the inputs after acceptance have no effect on the current frame.
- Bit timing:
  - cyc_cnt counts 0..P-1, where P is the latched prescale; the state advances when cyc_cnt==P-1.
  - prescale=0 gives P=64 (counter wraps naturally).
- States:
  - IDLE: tx_out=1.
  - START: tx_out=0 for P cycles, then DATA.
  - DATA: tx_out=data[bit_cnt], with bit_cnt running 0..DATA_WIDTH-1, LSB first.
    - After the last bit, go to PARITY if par_en was latched as 1, otherwise go to STOP.
  - PARITY: tx_out = XOR of the data bits when par_type=0 (even); XNOR when par_type=1 (odd). Lasts P cycles, then STOP.
  - STOP: tx_out=1 for P cycles, then IDLE with busy=0 on the following cycle.
- Frame length: busy is high for exactly (10+par_en)*P cycles when DATA_WIDTH=8.
- Back-to-back frames:
  - The earliest acceptance is the first IDLE cycle, where busy=0.
  - The next start bit then begins one cycle later, giving one idle-high clock of gap.
- Simultaneous events:
  - Reset dominates everything.
  - A data_valid pulse in the same cycle that STOP ends is not accepted.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*P cycles (two stop bits); busy length becomes (11+par_en)*P.
- Undefined: a single stop bit, as described above.

Test Plan:
- Reset idle: hold rst=0 then release, with data_valid=0 -> tx_out=1 and busy=0 continuously for 100 cycles.
- Basic frame: prescale=8, par_en=0, p_data=8'hA5, data_valid pulsed 1 cycle -> tx_out = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; busy high for 80 cycles.
- Even parity: prescale=8, par_en=1, par_type=0, p_data=8'hA5 -> parity bit 0 after the data bits, then stop 1; busy 88 cycles.
  - Odd parity, with p_data=8'h07 and par_type=1 -> parity bit 0; with par_type=0 -> parity bit 1.
- Busy blocking: send 8'h3C, pulse data_valid with 8'hFF mid-frame -> the frame still carries 3C bits and 8'hFF is never sent.
  - Back-to-back: hold data_valid=1 -> the second start bit begins exactly 1 idle cycle after the first stop ends.
- Reset mid-frame: assert rst=0 during DATA bit 3 -> tx_out=1 and busy=0 in the same cycle, without waiting for a clock edge.
  - After release, a new frame with 8'h55 is transmitted correctly.
- Prescale edge cases: prescale=1, 8'h81 -> one cycle per bit, 10-cycle frame; prescale=0 -> 64 cycles per bit.
  - With UART_TX_TWO_STOP_EN defined, the stop level lasts 2*P cycles.
